// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, state encoding and GF(2^8) helpers
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_NK = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } aes_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// rtl/aes_sub_word.sv - SubWord: four parallel S-boxes over a 32-bit word
module aes_sub_word (
    input  logic [31:0] word,
    output logic [31:0] sub
);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        sbox u_sbox (
            .a (word[8*i +: 8]),
            .s (sub[8*i +: 8])
        );
    end

endmodule

// File: rtl/sbox.sv
// rtl/sbox.sv - combinational AES forward S-box (inverse plus affine transform)
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);

    logic [7:0] inv;

    always_comb begin
        inv = gf_inv(a);
        s   = inv
            ^ {inv[6:0], inv[7]}
            ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]}
            ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - iterative AES-128 key schedule, one round key per clock
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int KW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] key_in,
    output logic          rk_valid,
    output logic [3:0]    rk_idx,
    output logic [KW-1:0] rk_out,
    output logic          busy,
    output logic          keys_ready,
    input  logic [3:0]    rd_addr,
    output logic [KW-1:0] rd_data
);

    localparam int NR = AES_NR;

    aes_state_t    state, state_nx;
    logic [3:0]    rnd;
    logic [7:0]    rcon;
    logic [KW-1:0] rk [0:NR];
    logic [KW-1:0] prev;
    logic [KW-1:0] nk;
    logic [31:0]   rw, sw, t, n0, n1, n2, n3;

    // previous round key is rk[rnd-1]; out-of-range rounds select zero
    always_comb begin
        prev = '0;
        for (int i = 0; i < NR; i++) begin
            if (rnd == 4'(i + 1)) prev = rk[i];
        end
    end

    assign rw = rot_word(prev[31:0]);

    aes_sub_word u_sub_word (
        .word (rw),
        .sub  (sw)
    );

    assign t  = sw ^ {rcon, 24'h0};
    assign n0 = prev[127:96] ^ t;
    assign n1 = prev[95:64]  ^ n0;
    assign n2 = prev[63:32]  ^ n1;
    assign n3 = prev[31:0]   ^ n2;
    assign nk = {n0, n1, n2, n3};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = EXPAND;
            EXPAND:     if (rnd == 4'(NR)) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    assign busy = (state == EXPAND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rnd        <= 4'd0;
            rcon       <= 8'h01;
            rk_valid   <= 1'b0;
            rk_idx     <= 4'd0;
            rk_out     <= '0;
            keys_ready <= 1'b0;
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
        end else begin
            state    <= state_nx;
            rk_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rk[0]      <= key_in;
                        rk_out     <= key_in;
                        rk_idx     <= 4'd0;
                        rk_valid   <= 1'b1;
                        rnd        <= 4'd1;
                        rcon       <= 8'h01;
                        keys_ready <= 1'b0;
                    end
                end
                EXPAND: begin
                    for (int i = 1; i <= NR; i++) begin
                        if (rnd == 4'(i)) rk[i] <= nk;
                    end
                    rk_out   <= nk;
                    rk_idx   <= rnd;
                    rk_valid <= 1'b1;
                    rcon     <= xtime(rcon);
                    rnd      <= rnd + 4'd1;
                    if (rnd == 4'(NR)) keys_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i <= NR; i++) begin
            if (rd_addr == 4'(i)) rd_data = rk[i];
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// tb/tb_aes_key_expand.sv - directed self-checking bench for aes_key_expand
module tb_aes_key_expand;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         rk_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         busy;
    logic         keys_ready;
    logic [3:0]   rd_addr;
    logic [127:0] rd_data;

    int passed;
    int total;

    logic [127:0] fips_rk [0:10];
    logic [127:0] zero_rk [0:10];
    logic [127:0] fips_key;
    logic [127:0] zero_key;

    aes_key_expand dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_in     (key_in),
        .rk_valid   (rk_valid),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out),
        .busy       (busy),
        .keys_ready (keys_ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic do_start(input logic [127:0] key);
        @(negedge clk);
        start  = 1'b1;
        key_in = key;
    endtask

    // which: 0 = FIPS key (all keys known), 1 = zero key (rk0, rk1, rk10 known)
    task automatic check_stream(input int which, input bit inject);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            start = inject && (k == 3);
            if (inject && k == 3) key_in = zero_key;
            chk($sformatf("valid[%0d]", k), {127'd0, rk_valid}, 128'd1);
            chk($sformatf("idx[%0d]", k), {124'd0, rk_idx}, 128'(k));
            chk($sformatf("busy[%0d]", k), {127'd0, busy}, {127'd0, (k < 10)});
            chk($sformatf("ready[%0d]", k), {127'd0, keys_ready}, {127'd0, (k == 10)});
            if (which == 0)
                chk($sformatf("fips_rk[%0d]", k), rk_out, fips_rk[k]);
            else if (k == 0 || k == 1 || k == 10)
                chk($sformatf("zero_rk[%0d]", k), rk_out, zero_rk[k]);
        end
        start = 1'b0;
        @(negedge clk);
        chk("valid_after", {127'd0, rk_valid}, 128'd0);
        chk("ready_hold", {127'd0, keys_ready}, 128'd1);
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        zero_key = 128'h0;
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i <= 10; i++) zero_rk[i] = 128'h0;
        zero_rk[1]  = 128'h62636363626363636263636362636363;
        zero_rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        rst     = 1'b1;
        start   = 1'b0;
        key_in  = '0;
        rd_addr = 4'd0;
        #12;
        chk("rst_valid", {127'd0, rk_valid}, 128'd0);
        chk("rst_idx", {124'd0, rk_idx}, 128'd0);
        chk("rst_out", rk_out, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_ready", {127'd0, keys_ready}, 128'd0);
        chk("rst_rd0", rd_data, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_valid", {127'd0, rk_valid}, 128'd0);

        // FIPS key with an ignored restart attempt mid-expansion
        do_start(fips_key);
        check_stream(0, 1'b1);

        for (int a = 0; a <= 10; a++) begin
            rd_addr = 4'(a);
            #1;
            chk($sformatf("rd[%0d]", a), rd_data, fips_rk[a]);
        end
        rd_addr = 4'd11;
        #1;
        chk("rd[11]", rd_data, 128'd0);
        rd_addr = 4'd15;
        #1;
        chk("rd[15]", rd_data, 128'd0);

        // restart from DONE with the zero key
        do_start(zero_key);
        rd_addr = 4'd5;
        check_stream(1, 1'b0);

        // asynchronous reset between edges mid-expansion
        do_start(fips_key);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("mid_busy", {127'd0, busy}, 128'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {127'd0, rk_valid}, 128'd0);
        chk("arst_idx", {124'd0, rk_idx}, 128'd0);
        chk("arst_out", rk_out, 128'd0);
        chk("arst_busy", {127'd0, busy}, 128'd0);
        chk("arst_ready", {127'd0, keys_ready}, 128'd0);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            chk($sformatf("arst_rd[%0d]", a), rd_data, 128'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start(fips_key);
        check_stream(0, 1'b0);
        rd_addr = 4'd10;
        #1;
        chk("final_rd10", rd_data, fips_rk[10]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
Iterative AES-128 key schedule. It sits directly downstream of the S-box and consumes four `sbox` instances to compute SubWord(RotWord(w3)). It expands a 128-bit cipher key into round keys 0..10, producing one round key per clock. Keys are held in an internal register file that the AES round datapath reads; each round key is also streamed out with a valid pulse.

Parameters:
NR, 10, number of rounds; fixed for AES-128, must not be overridden.
KW, 128, key and round-key width in bits.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  single-cycle request; sampled only in IDLE or DONE.
key_in  in  128  cipher key; w0 = key_in[127:96], w3 = key_in[31:0]; sampled with start.
rk_valid  out  1  one-cycle pulse when a round key is written.
rk_idx  out  4  index 0..10 of the key on rk_out; qualified by rk_valid.
rk_out  out  128  round key just written; qualified by rk_valid.
busy  out  1  high in EXPAND.
keys_ready  out  1  high in DONE: all 11 keys valid.
rd_addr  in  4  register-file read index.
rd_data  out  128  combinational read of rk[rd_addr]; addresses 11..15 return 0.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; rk_valid=0, rk_idx=0, rk_out=0, busy=0, keys_ready=0; all 11 register-file entries=0; rcon=8'h01; round counter=0.
- States:
  - IDLE: on start, go to EXPAND.
  - EXPAND: runs for 10 cycles, then goes to DONE.
  - DONE: on start, go back to EXPAND.
- Start edge (IDLE or DONE):
  - rk[0] <= key_in; rk_out <= key_in; rk_idx <= 0; rk_valid <= 1.
  - Round counter <= 1; rcon <= 8'h01; keys_ready <= 0.
- EXPAND, each edge with round counter r (1..10):
  - prev = rk[r-1], split into words w0..w3.
  - t = SubWord({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0}.
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
  - rk[r] <= {n0,n1,n2,n3}; rk_out/rk_idx/rk_valid pulse accordingly.
  - rcon <= xtime(rcon): shift left 1, XOR 8'h1b if the msb was 1. Sequence is 01,02,04,08,10,20,40,80,1b,36.
  - r == 10: next state DONE, keys_ready <= 1 on the same edge.
- Latency: start sampled at edge 0; rk10 is written and keys_ready rises at edge 10. That gives 11 rk_valid pulses on consecutive cycles.
- rk_valid is 0 in every cycle without a write.
- start during EXPAND is ignored: no restart and no key_in capture.
- start in DONE restarts expansion. keys_ready falls at that same edge; the old rk[1..10] remain readable but stale until overwritten.
- Reset mid-expansion: immediate return to the full reset state; no partial keys_ready.
- SubWord uses 4 parallel `sbox` instances, purely combinational within one cycle; there is no pipeline register.
- rd_data is a combinational mux with no read latency.

Decomposition:
- Shared package `aes_pkg`:
  - constants AES_NR=10, AES_NK=4.
  - state encoding IDLE=2'd0, EXPAND=2'd1, DONE=2'd2.
  - function xtime(byte).
  - function rot_word(word).
- Sub-module: `aes_sub_word`, a 32-bit wrapper of four `sbox` instances, reusable by the round datapath.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start -> rk_idx1 = a0fafe1788542cb123a339392a6c7605; rk_idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6; keys_ready rises exactly 10 cycles after the start edge.
- All-zero key -> rk1 = 62636363626363636263636362636363, rk10 = b4ef5bcb3e92e21123e951cf6f8f188e; exactly 11 rk_valid pulses with idx 0..10.
- Readback after DONE: rd_addr=0..10 matches the streamed keys; rd_addr=11 and 15 -> 0.
- Second start at the 4th EXPAND cycle with a different key_in -> ignored; final keys match the first key.
- Start in DONE with the zero key after the FIPS key -> keys_ready drops for 10 cycles, then rk10 = b4ef5bcb…8e.
- rst asserted asynchronously mid-EXPAND (between edges) -> outputs zero immediately; rd_data for every address is 0; a subsequent start produces the correct full schedule.
